// File: rtl/processador_pkg.sv
// processador_pkg: opcodes, fetch-state encoding and default widths shared by the processor blocks
package processador_pkg;
  localparam int PC_WIDTH_DEF    = 8;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  typedef enum logic [1:0] {OCIOSO, BUSCA, PRONTO, PARADO} estado_busca_t;
endpackage

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: req/ack instruction-memory bus between the fetch unit and memory
interface busca_instrucao_if #(
  parameter int PC_WIDTH    = processador_pkg::PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = processador_pkg::INSTR_WIDTH_DEF
);
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/contador_programa.sv
// contador_programa: PC register with next-PC mux and a one-entry pending write held while a fetch is in flight
module contador_programa #(
  parameter int PC_WIDTH = processador_pkg::PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                fonte,
  input  logic [PC_WIDTH-1:0] alvo,
  input  logic                defer,
  output logic [PC_WIDTH-1:0] pc
);
  logic [PC_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, novo;
  logic                pend_v_q, pend_v_d;
  always_comb begin
    novo     = fonte ? alvo : PC_WIDTH'(pc_q + 1'b1);
    // a direct write outside a fetch takes priority over a pending value released at the same edge
    pc_d     = defer ? pc_q : wr_en ? novo : pend_v_q ? pend_q : pc_q;
    pend_v_d = defer & (pend_v_q | wr_en);
    pend_d   = (defer & wr_en) ? novo : pend_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  assign pc = pc_q;
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch FSM and IR, issuing req/ack fetches and applying control PC-write strobes
module busca_instrucao
  import processador_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EscIR,
  input  logic                   EscCP,
  input  logic                   EscCondCP,
  input  logic                   FonteCP,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    alvo_cp,
  busca_instrucao_if.master      mem,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   instr_valid,
  output logic                   ocupado,
  output logic                   parado
);
  estado_busca_t          state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic                   mem_req_q, mem_req_d, instr_valid_q, instr_valid_d;
  logic                   launch, accept, pc_we;
  assign launch = (state_q == OCIOSO || state_q == PRONTO) && EscIR;
  assign accept = (state_q == BUSCA) && mem.mem_ack;
  assign pc_we  = (EscCP | (EscCondCP & zero)) && state_q != PARADO;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= OCIOSO;
      ir_q          <= '0;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  always_comb begin
    state_d = state_q == PARADO ? PARADO :
              state_q == BUSCA  ? (!mem.mem_ack ? BUSCA :
                                   mem.mem_rdata[INSTR_WIDTH-1 -: 4] == OP_HALT ? PARADO : PRONTO) :
              launch ? BUSCA : state_q;
  end
  always_comb begin
    mem_req_d     = launch | (state_q == BUSCA && !mem.mem_ack);
    mem_addr_d    = launch ? pc : mem_addr_q;
    ir_d          = accept ? mem.mem_rdata : ir_q;
    instr_valid_d = accept ? 1'b1 : launch ? 1'b0 : instr_valid_q;
  end
  contador_programa #(.PC_WIDTH(PC_WIDTH)) u_cp (
    .clk   (clk),
    .rst   (rst),
    .wr_en (pc_we),
    .fonte (FonteCP),
    .alvo  (alvo_cp),
    .defer (state_q == BUSCA),
    .pc    (pc)
  );
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign instr        = ir_q;
  assign opcode       = ir_q[INSTR_WIDTH-1 -: 4];
  assign instr_valid  = instr_valid_q;
  assign ocupado      = state_q == BUSCA;
  assign parado       = state_q == PARADO;
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed checks of fetch handshake, PC writes, deferral, halt and reset
module tb_busca_instrucao;
  logic        clk = 1'b0, rst = 1'b1;
  logic        EscIR = 0, EscCP = 0, EscCondCP = 0, FonteCP = 0, zero = 0;
  logic [7:0]  alvo_cp = '0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc;
  logic        instr_valid, ocupado, parado;
  int          checks = 0, errors = 0;
  busca_instrucao_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) mem ();
  busca_instrucao #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP),
    .FonteCP(FonteCP), .zero(zero), .alvo_cp(alvo_cp), .mem(mem.master),
    .instr(instr), .opcode(opcode), .pc(pc), .instr_valid(instr_valid),
    .ocupado(ocupado), .parado(parado)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    EscIR = 0; EscCP = 0; EscCondCP = 0; FonteCP = 0; zero = 0;
  endtask
  task automatic ack(input logic [15:0] d);
    mem.mem_ack = 1; mem.mem_rdata = d;
    @(negedge clk);
    mem.mem_ack = 0;
  endtask
  initial begin
    mem.mem_ack = 0; mem.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_ir", instr, 0);
    check("rst_op", opcode, 0);
    check("rst_req", mem.mem_req, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", ocupado, 0);
    check("rst_halt", parado, 0);
    rst = 0;
    @(negedge clk);
    // first fetch, ack three edges after the strobe
    EscIR = 1; @(negedge clk); clr();
    check("f1_req", mem.mem_req, 1);
    check("f1_addr", mem.mem_addr, 0);
    check("f1_busy", ocupado, 1);
    check("f1_valid_lo", instr_valid, 0);
    repeat (2) @(negedge clk);
    check("f1_wait_req", mem.mem_req, 1);
    ack(16'hB123);
    check("f1_op", opcode, 4'hB);
    check("f1_valid", instr_valid, 1);
    check("f1_req_lo", mem.mem_req, 0);
    check("f1_idle", ocupado, 0);
    // move pc to 5 from PRONTO
    EscCP = 1; FonteCP = 1; alvo_cp = 8'h05; @(negedge clk); clr();
    check("pc5", pc, 8'h05);
    // fetch and PC+1 at the same edge: fetch uses old pc
    EscIR = 1; EscCP = 1; @(negedge clk); clr();
    check("f2_addr", mem.mem_addr, 8'h05);
    check("f2_pc", pc, 8'h06);
    // conditional write taken during BUSCA is deferred past the ack edge
    EscCondCP = 1; zero = 1; FonteCP = 1; alvo_cp = 8'h40; @(negedge clk); clr();
    check("def_pc_busy", pc, 8'h06);
    ack(16'h2000);
    check("def_pc_ack", pc, 8'h06);
    check("f2_instr", instr, 16'h2000);
    @(negedge clk);
    check("def_pc_apply", pc, 8'h40);
    // same, with zero=0: no write
    EscIR = 1; @(negedge clk); clr();
    EscCondCP = 1; zero = 0; FonteCP = 1; alvo_cp = 8'h77; @(negedge clk); clr();
    ack(16'h2100);
    @(negedge clk);
    check("nz_pc", pc, 8'h40);
    // two deferred writes, the second coinciding with the ack: last wins
    EscIR = 1; @(negedge clk); clr();
    EscCP = 1; FonteCP = 1; alvo_cp = 8'h10; @(negedge clk);
    alvo_cp = 8'h30; ack(16'h3456); clr();
    check("lw_pc_ack", pc, 8'h40);
    @(negedge clk);
    check("lw_pc_apply", pc, 8'h30);
    // ack without a request is ignored
    mem.mem_ack = 1; mem.mem_rdata = 16'hABCD; @(negedge clk); mem.mem_ack = 0;
    check("stray_ack_ir", instr, 16'h3456);
    check("stray_ack_busy", ocupado, 0);
    // wraparound
    EscCP = 1; FonteCP = 1; alvo_cp = 8'hFF; @(negedge clk);
    FonteCP = 0; @(negedge clk); clr();
    check("wrap_pc", pc, 8'h00);
    // halt
    EscIR = 1; @(negedge clk); clr();
    ack(16'hF000);
    check("halt_parado", parado, 1);
    check("halt_valid", instr_valid, 1);
    check("halt_op", opcode, 4'hF);
    EscIR = 1; EscCP = 1; FonteCP = 1; alvo_cp = 8'h55; repeat (2) @(negedge clk); clr();
    check("halt_req", mem.mem_req, 0);
    check("halt_pc", pc, 8'h00);
    check("halt_stay", parado, 1);
    // reset while fetching, with a pending write queued
    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
    check("unhalt", parado, 0);
    EscIR = 1; @(negedge clk); clr();
    EscCP = 1; FonteCP = 1; alvo_cp = 8'h99; @(negedge clk); clr();
    check("mid_req", mem.mem_req, 1);
    #1 rst = 1; #1;
    check("mid_req_async", mem.mem_req, 0);
    check("mid_busy", ocupado, 0);
    @(negedge clk); rst = 0;
    ack(16'h1234);
    check("post_ir", instr, 0);
    check("post_valid", instr_valid, 0);
    @(negedge clk);
    check("post_pc", pc, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
